npu_bus_master: RTL
===================

Name: npu_bus_master

Overview:
- Initiator side of the NPU memory-mapped slave port (cen/wen/addr/wdata/rdata).
- Accepts one job per valid/ready command, which carries an operation type and an input word.
- Issues the bus sequence: write TYPE, write INPUT, optional wait, read OUTPUT.
- Returns the read word on a valid/ready response channel. Sits between a host sequencer/DMA and the NPU slave.

Parameters:
- DWidth, 32, data and address width of the bus and command/response channels.
- BaseAddr, 32'h0, NPU base address; register offsets are added to it.
- WaitCycles, 0, idle cycles between the INPUT write and the OUTPUT read (0..255).
- ReadLatency, 1, cycles from the read-request cycle to the cycle in which rdata_i is valid (1..4).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- cmd_valid_i  input  1  job request valid
- cmd_ready_o  output  1  master can accept a job
- cmd_type_i  input  DWidth  operation type word
- cmd_data_i  input  DWidth  input operand word
- rsp_valid_o  output  1  result valid
- rsp_ready_i  input  1  consumer accepts result
- rsp_data_o  output  DWidth  result word
- busy_o  output  1  job in flight (state != IDLE)
- cen_o  output  1  bus select, active-high
- wen_o  output  1  1 = write, 0 = read; meaningful only when cen_o = 1
- addr_o  output  DWidth  bus address
- wdata_o  output  DWidth  bus write data
- rdata_i  input  DWidth  bus read data

Behaviour:
- Reset (async, active-high) forces the following, regardless of state mid-job:
  - State = IDLE.
  - cen_o = 0, wen_o = 0, addr_o = 0, wdata_o = 0.
  - rsp_valid_o = 0, rsp_data_o = 0, busy_o = 0.
  - Latched type/data and all counters = 0.
- An in-flight bus transaction is abandoned at reset; no retry follows.
- Offsets: TYPE = +0x0, INPUT = +0x4, OUTPUT = +0x8. addr_o = BaseAddr + offset, modulo 2^DWidth.
- All bus outputs are registered. Bus outputs are 0 in every state not listed below.
- cmd_ready_o = (state == IDLE). A job is accepted when cmd_valid_i & cmd_ready_o, which latches cmd_type_i and cmd_data_i.
- FSM states and transitions:
  - IDLE -> WR_TYPE on accept.
  - WR_TYPE (1 cycle): cen=1, wen=1, addr=Base+0, wdata=type. Goes to WR_INPUT.
  - WR_INPUT (1 cycle): cen=1, wen=1, addr=Base+4, wdata=data. Goes to WAIT if WaitCycles > 0, else RD_REQ.
  - WAIT: counter loads WaitCycles-1 and decrements; exits to RD_REQ at 0. Bus is idle.
  - RD_REQ (1 cycle): cen=1, wen=0, addr=Base+8. Goes to RD_WAIT with counter = ReadLatency-1.
  - RD_WAIT: when counter == 0, captures rdata_i into rsp_data_o and goes to RESP; otherwise decrements.
  - RESP: rsp_valid_o = 1. rsp_data_o is held stable until rsp_ready_i, then goes to IDLE.
- Latency with WaitCycles=0, ReadLatency=1:
  - Accept in cycle 0.
  - Bus writes in cycles 1 and 2; read request in cycle 3.
  - rdata_i sampled in cycle 4; rsp_valid_o rises in cycle 5.
- Back-to-back jobs: the next accept is possible in the cycle after the response handshake. There is at most one job in flight.
- cmd_* inputs changing while busy are ignored. rsp_ready_i outside RESP is ignored.
- rdata_i is sampled only in the capture cycle; X on rdata_i at other times has no effect.

Optional Feature:
- NPU_BUS_MASTER_TYPE_CACHE_EN defined:
  - A last_type register holds the last written type; a type_vld flag is cleared by reset.
  - On accept, if type_vld && cmd_type_i == last_type, WR_TYPE is skipped (IDLE -> WR_INPUT), saving 1 cycle.
  - Otherwise WR_TYPE executes and last_type/type_vld are updated.
- Not defined: WR_TYPE is issued for every job.

Decomposition:
- Package npu_bus_pkg holds:
  - The state enum (IDLE, WR_TYPE, WR_INPUT, WAIT, RD_REQ, RD_WAIT, RESP).
  - Offset constants TYPE_OFS = 'h0, INPUT_OFS = 'h4, OUTPUT_OFS = 'h8.
- One sub-module, npu_bus_cnt: a loadable down-counter with a zero flag, shared by WAIT and RD_WAIT.

Test Plan:
- Reset mid-RD_WAIT (rst_i pulse) -> all outputs 0 in the same cycle, cmd_ready_o = 1 after release, and no stale rsp_valid_o.
- Single job (type=0x1, data=0xA5, WaitCycles=0, Base=0), with the slave returning 0x1234 -> bus sequence:
  - W@0x0=0x1, W@0x4=0xA5, R@0x8.
  - rsp_valid_o in cycle 5 with rsp_data_o = 0x1234.
- WaitCycles=3, ReadLatency=2, Base=0x1000 -> exactly 3 idle bus cycles between W@0x1004 and R@0x1008. Capture occurs 2 cycles after R.
- Response backpressure: rsp_ready_i held low for 10 cycles -> rsp_valid_o stays 1, rsp_data_o stable, and a new cmd_valid_i is not accepted (cmd_ready_o = 0).
- Back-to-back jobs (types 0x2, 0x2), rsp_ready_i tied 1:
  - Without the macro: 2 TYPE writes and 2 responses.
  - With NPU_BUS_MASTER_TYPE_CACHE_EN: the second job issues no W@0x0 and its response arrives 1 cycle earlier.
- Address wrap: Base=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/npu_bus_pkg.sv
// npu_bus_pkg: shared types and constants for the NPU bus master.
// Holds the FSM state enum, NPU register offsets and the counter width.
package npu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_TYPE,
        WR_INPUT,
        WAIT,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_e;

    localparam int unsigned TYPE_OFS   = 'h0;
    localparam int unsigned INPUT_OFS  = 'h4;
    localparam int unsigned OUTPUT_OFS = 'h8;

    // Wide enough for WaitCycles-1 (<= 254) and ReadLatency-1 (<= 3).
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/npu_bus_cnt.sv
// npu_bus_cnt: loadable down-counter with zero flag, shared by WAIT/RD_WAIT.
// Ports: clk_i, rst_i (async high), load_i/load_val_i, dec_i, zero_o.
module npu_bus_cnt
    import npu_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/npu_bus_master.sv
// npu_bus_master: runs one NPU job per command (write TYPE, write INPUT,
// optional wait, read OUTPUT) and returns the read word on a rsp channel.
// Ports: clk_i/rst_i (async high); cmd_valid_i/cmd_ready_o/cmd_type_i/
// cmd_data_i; rsp_valid_o/rsp_ready_i/rsp_data_o; busy_o;
// bus cen_o/wen_o/addr_o/wdata_o/rdata_i (all bus outputs registered).
// Optional: NPU_BUS_MASTER_TYPE_CACHE_EN skips WR_TYPE when the type repeats.
module npu_bus_master
    import npu_bus_pkg::*;
#(
    parameter int unsigned       DWidth      = 32,
    parameter logic [DWidth-1:0] BaseAddr    = '0,
    parameter int unsigned       WaitCycles  = 0,
    parameter int unsigned       ReadLatency = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DWidth-1:0] cmd_type_i,
    input  logic [DWidth-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWidth-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              cen_o,
    output logic              wen_o,
    output logic [DWidth-1:0] addr_o,
    output logic [DWidth-1:0] wdata_o,
    input  logic [DWidth-1:0] rdata_i
);

    // Addresses wrap modulo 2^DWidth by truncation of the sum.
    localparam logic [DWidth-1:0] AddrType = BaseAddr + DWidth'(TYPE_OFS);
    localparam logic [DWidth-1:0] AddrIn   = BaseAddr + DWidth'(INPUT_OFS);
    localparam logic [DWidth-1:0] AddrOut  = BaseAddr + DWidth'(OUTPUT_OFS);
    localparam bit                HasWait  = (WaitCycles != 0);
    localparam logic [CNT_W-1:0]  WaitLd   = CNT_W'(WaitCycles - 1);
    localparam logic [CNT_W-1:0]  RdLd     = CNT_W'(ReadLatency - 1);

    state_e            state_q;
    logic              cen_q;
    logic              wen_q;
    logic [DWidth-1:0] addr_q;
    logic [DWidth-1:0] wdata_q;
    logic [DWidth-1:0] data_q;
    logic              rsp_valid_q;
    logic [DWidth-1:0] rsp_data_q;
`ifdef NPU_BUS_MASTER_TYPE_CACHE_EN
    logic [DWidth-1:0] last_type_q;
    logic              type_vld_q;
`endif

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    // Counter is loaded in the cycle before WAIT/RD_WAIT is entered.
    assign cnt_load = ((state_q == WR_INPUT) && HasWait) || (state_q == RD_REQ);
    assign cnt_val  = (state_q == RD_REQ) ? RdLd : WaitLd;
    assign cnt_dec  = (state_q == WAIT) || (state_q == RD_WAIT);

    npu_bus_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Bus outputs are set on the edge that enters the bus state, so they
    // are valid for exactly the cycle spent in that state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cen_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef NPU_BUS_MASTER_TYPE_CACHE_EN
            last_type_q <= '0;
            type_vld_q  <= 1'b0;
`endif
        end else begin
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        data_q  <= cmd_data_i;
                        state_q <= WR_TYPE;
                        cen_q   <= 1'b1;
                        wen_q   <= 1'b1;
                        addr_q  <= AddrType;
                        wdata_q <= cmd_type_i;
`ifdef NPU_BUS_MASTER_TYPE_CACHE_EN
                        if (type_vld_q && (cmd_type_i == last_type_q)) begin
                            state_q <= WR_INPUT;
                            addr_q  <= AddrIn;
                            wdata_q <= cmd_data_i;
                        end else begin
                            last_type_q <= cmd_type_i;
                            type_vld_q  <= 1'b1;
                        end
`endif
                    end
                end
                WR_TYPE: begin
                    state_q <= WR_INPUT;
                    cen_q   <= 1'b1;
                    wen_q   <= 1'b1;
                    addr_q  <= AddrIn;
                    wdata_q <= data_q;
                end
                WR_INPUT: begin
                    if (HasWait) begin
                        state_q <= WAIT;
                    end else begin
                        state_q <= RD_REQ;
                        cen_q   <= 1'b1;
                        addr_q  <= AddrOut;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state_q <= RD_REQ;
                        cen_q   <= 1'b1;
                        addr_q  <= AddrOut;
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt_zero) begin
                        rsp_data_q  <= rdata_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign cen_o       = cen_q;
    assign wen_o       = wen_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;

endmodule
